// File: rtl/score_display_ctrl.sv
// Score display sequencer: BCD live/high score counters, game-over flash and
// new-record hold, with registered digit/blank outputs for the 7-segment decoder.
module score_display_ctrl #(
    parameter int CLKS_PER_BLINK = 12_500_000,
    parameter int BLINK_COUNT    = 3,
    parameter int HIGH_SHOW_CLKS = 50_000_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Score_Inc,
    input  logic       i_Game_Over,
    input  logic       i_Show_High,
    output logic [3:0] o_Tens,
    output logic [3:0] o_Units,
    output logic       o_Blank,
    output logic [6:0] o_Score,
    output logic [6:0] o_High_Score,
    output logic       o_Busy
);

    localparam int MAX_CLKS = (CLKS_PER_BLINK > HIGH_SHOW_CLKS) ? CLKS_PER_BLINK : HIGH_SHOW_CLKS;
    localparam int TMR_W    = $clog2(MAX_CLKS);
    localparam int HALVES   = 2 * BLINK_COUNT;
    localparam int BLK_W    = $clog2(HALVES);

    localparam logic [TMR_W-1:0] BLINK_LAST = TMR_W'(CLKS_PER_BLINK - 1);
    localparam logic [TMR_W-1:0] SHOW_LAST  = TMR_W'(HIGH_SHOW_CLKS - 1);
    localparam logic [BLK_W-1:0] HALF_LAST  = BLK_W'(HALVES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLASH,
        ST_SHOW_HIGH
    } state_t;

    state_t           r_state, w_state_next;
    logic [7:0]       r_live, w_live_next;
    logic [7:0]       r_high, w_high_next;
    logic [7:0]       r_frz, w_frz_next;
    logic             r_rec, w_rec_next;
    logic [TMR_W-1:0] r_timer, w_timer_next;
    logic [BLK_W-1:0] r_blink, w_blink_next;
    logic             r_show;
    logic [7:0]       w_live_inc;
    logic [7:0]       w_disp;

    // Saturating BCD increment on a {tens, units} pair; 99 stays 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
    endfunction

    assign w_live_inc = i_Score_Inc ? bcd_inc(r_live) : r_live;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= ST_RUN;
            r_live  <= 8'h00;
            r_high  <= 8'h00;
            r_frz   <= 8'h00;
            r_rec   <= 1'b0;
            r_timer <= '0;
            r_blink <= '0;
            r_show  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= w_live_next;
            r_high  <= w_high_next;
            r_frz   <= w_frz_next;
            r_rec   <= w_rec_next;
            r_timer <= w_timer_next;
            r_blink <= w_blink_next;
            r_show  <= i_Show_High;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_live_next  = w_live_inc;
        w_high_next  = r_high;
        w_frz_next   = r_frz;
        w_rec_next   = r_rec;
        w_timer_next = r_timer;
        w_blink_next = r_blink;
        case (r_state)
            ST_RUN: begin
                // BCD pairs compare lexicographically as plain 8-bit values.
                if (i_Game_Over) begin
                    w_frz_next = w_live_inc;
                    if (w_live_inc > r_high) begin
                        w_high_next = w_live_inc;
                        w_rec_next  = 1'b1;
                    end
                    w_live_next  = 8'h00;
                    w_timer_next = '0;
                    w_blink_next = '0;
                    w_state_next = ST_FLASH;
                end
            end
            ST_FLASH: begin
                if (r_timer == BLINK_LAST) begin
                    w_timer_next = '0;
                    if (r_blink == HALF_LAST)
                        w_state_next = r_rec ? ST_SHOW_HIGH : ST_RUN;
                    else
                        w_blink_next = r_blink + 1'b1;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            ST_SHOW_HIGH: begin
                if (r_timer == SHOW_LAST) begin
                    w_timer_next = '0;
                    w_rec_next   = 1'b0;
                    w_state_next = ST_RUN;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_comb begin
        w_disp = r_live;
        case (r_state)
            ST_RUN:       w_disp = r_show ? r_high : r_live;
            ST_FLASH:     w_disp = r_frz;
            ST_SHOW_HIGH: w_disp = r_high;
            default:      w_disp = r_live;
        endcase
    end

    // Output register stage: every output reflects the state one edge earlier.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Tens       <= 4'd0;
            o_Units      <= 4'd0;
            o_Blank      <= 1'b0;
            o_Score      <= 7'd0;
            o_High_Score <= 7'd0;
            o_Busy       <= 1'b0;
        end else begin
            o_Tens       <= w_disp[7:4];
            o_Units      <= w_disp[3:0];
            o_Blank      <= (r_state == ST_FLASH) && !r_blink[0];
            o_Score      <= bcd_to_bin(r_live);
            o_High_Score <= bcd_to_bin(r_high);
            o_Busy       <= (r_state != ST_RUN);
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: directed scenarios plus random pulses, checked
// every cycle against an integer phase/count reference model.
module tb_score_display_ctrl;

    localparam int CPB = 4;
    localparam int BC  = 2;
    localparam int HSC = 6;
    localparam int FLASH_LEN = 2 * BC * CPB;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_Score_Inc = 1'b0;
    logic       i_Game_Over = 1'b0;
    logic       i_Show_High = 1'b0;
    logic [3:0] o_Tens, o_Units;
    logic       o_Blank, o_Busy;
    logic [6:0] o_Score, o_High_Score;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain integers, phase 0=run 1=flash 2=show-high.
    int m_live, m_high, m_frz, m_rec, m_phase, m_cnt, m_show;

    score_display_ctrl #(
        .CLKS_PER_BLINK(CPB),
        .BLINK_COUNT   (BC),
        .HIGH_SHOW_CLKS(HSC)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Score_Inc (i_Score_Inc),
        .i_Game_Over (i_Game_Over),
        .i_Show_High (i_Show_High),
        .o_Tens      (o_Tens),
        .o_Units     (o_Units),
        .o_Blank     (o_Blank),
        .o_Score     (o_Score),
        .o_High_Score(o_High_Score),
        .o_Busy      (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_live = 0; m_high = 0; m_frz = 0; m_rec = 0;
        m_phase = 0; m_cnt = 0; m_show = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tens"},  32'(o_Tens), 0);
        check({tag, "_units"}, 32'(o_Units), 0);
        check({tag, "_blank"}, 32'(o_Blank), 0);
        check({tag, "_score"}, 32'(o_Score), 0);
        check({tag, "_high"},  32'(o_High_Score), 0);
        check({tag, "_busy"},  32'(o_Busy), 0);
    endtask

    // One clock: drive inputs, predict the registered outputs from the model
    // state before the edge, advance the model, then compare.
    task automatic tick(input logic inc, input logic go, input logic show);
        int e_disp, e_blank, e_busy, e_score, e_high, inc_v;
        i_Score_Inc = inc;
        i_Game_Over = go;
        i_Show_High = show;
        @(posedge i_Clk);
        e_score = m_live;
        e_high  = m_high;
        e_busy  = (m_phase != 0);
        e_blank = (m_phase == 1) && (((m_cnt / CPB) % 2) == 0);
        if (m_phase == 0)      e_disp = m_show ? m_high : m_live;
        else if (m_phase == 1) e_disp = m_frz;
        else                   e_disp = m_high;

        inc_v = inc ? ((m_live < 99) ? m_live + 1 : 99) : m_live;
        m_show = show;
        if (m_phase == 0) begin
            if (go) begin
                m_frz = inc_v;
                if (m_frz > m_high) begin
                    m_high = m_frz;
                    m_rec  = 1;
                end
                m_live = 0; m_phase = 1; m_cnt = 0;
            end else begin
                m_live = inc_v;
            end
        end else if (m_phase == 1) begin
            m_live = inc_v;
            m_cnt++;
            if (m_cnt == FLASH_LEN) begin
                m_phase = m_rec ? 2 : 0;
                m_cnt = 0;
            end
        end else begin
            m_live = inc_v;
            m_cnt++;
            if (m_cnt == HSC) begin
                m_rec = 0; m_phase = 0; m_cnt = 0;
            end
        end

        #1;
        check("tens",  32'(o_Tens), 32'(e_disp / 10));
        check("units", 32'(o_Units), 32'(e_disp % 10));
        check("blank", 32'(o_Blank), 32'(e_blank));
        check("score", 32'(o_Score), 32'(e_score));
        check("high",  32'(o_High_Score), 32'(e_high));
        check("busy",  32'(o_Busy), 32'(e_busy));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2;
        i_Rst_L = 1'b0;
        i_Score_Inc = 1'b0; i_Game_Over = 1'b0; i_Show_High = 1'b0;
        #1;
        check_all_zero({tag, "_async"});
        model_reset();
        repeat (2) @(posedge i_Clk);
        #1;
        check_all_zero({tag, "_held"});
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
    endtask

    task automatic run_busy(input string tag, input int exp_len);
        int cnt;
        bit seen;
        cnt = 0; seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (o_Busy) begin
                cnt++;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        check(tag, 32'(cnt), 32'(exp_len));
    endtask

    initial begin
        model_reset();
        #1;
        check_all_zero("por");
        @(negedge i_Clk);
        i_Rst_L = 1'b1;

        // Count and saturation
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("cnt12_tens", 32'(o_Tens), 1);
        check("cnt12_units", 32'(o_Units), 2);
        check("cnt12_score", 32'(o_Score), 12);
        for (int i = 0; i < 100; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("sat_score", 32'(o_Score), 99);
        check("sat_tens", 32'(o_Tens), 9);

        // First record: 16 flash + 6 show-high cycles
        do_reset("rst1");
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        run_busy("rec_busy_len", FLASH_LEN + HSC);
        check("rec_high", 32'(o_High_Score), 7);
        check("rec_units", 32'(o_Units), 0);

        // Equal score is not a record: flash only
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        run_busy("norec_busy_len", FLASH_LEN);
        check("norec_high", 32'(o_High_Score), 7);

        // Simultaneous increment and game-over, then increments during flash
        for (int i = 0; i < 41; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("sim_tens", 32'(o_Tens), 4);
        check("sim_units", 32'(o_Units), 2);
        check("sim_high", 32'(o_High_Score), 42);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
        check("sim_hold_units", 32'(o_Units), 2);
        run_busy("sim_busy_len", FLASH_LEN + HSC - 4);
        check("sim_score", 32'(o_Score), 3);

        // Show high in RUN
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("show_tens", 32'(o_Tens), 4);
        check("show_units", 32'(o_Units), 2);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("unshow_tens", 32'(o_Tens), 0);
        check("unshow_units", 32'(o_Units), 5);

        // Reset in the middle of a flash
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1);
        check("mid_busy_pre", 32'(o_Busy), 1);
        do_reset("rst_mid");
        tick(1'b0, 1'b0, 1'b0);

        // Random pulses against the model
        for (int i = 0; i < 600; i++)
            tick(1'(($urandom % 3) == 0), 1'(($urandom % 40) == 0), 1'($urandom % 2));
        do_reset("rst_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Sequencing controller for the two-digit score display. It keeps the live score and the high score as BCD counters and decides what the tens and units digit decoders show. On game over it flashes the final score, and on a new record it holds the high score on screen. It sits between the frog movement logic, which produces the score and game-over pulses, and the 7-segment decoder, which takes two 4-bit BCD digits.

## Interface
- CLKS_PER_BLINK, 12_500_000: clocks per blink half-period (0.5 s at 25 MHz); must be ≥ 2.
- BLINK_COUNT, 3: number of off/on blink pairs in the game-over flash; must be ≥ 1.
- HIGH_SHOW_CLKS, 50_000_000: clocks the new high score is held on display; must be ≥ 2.

Ports:
- i_Clk  in  1  system clock; all state changes on rising edge.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_Score_Inc  in  1  single-cycle pulse: add 1 to live score.
- i_Game_Over  in  1  single-cycle pulse: end of game.
- i_Show_High  in  1  level: while high in RUN, display the high score instead of the live score.
- o_Tens  out  4  BCD tens digit to the decoder, 0..9.
- o_Units  out  4  BCD units digit to the decoder, 0..9.
- o_Blank  out  1  1 = decoder must drive both digits dark.
- o_Score  out  7  live score, binary 0..99.
- o_High_Score  out  7  high score, binary 0..99.
- o_Busy  out  1  1 while in FLASH or SHOW_HIGH.

## Operation
- Live score is a BCD pair (units, tens).
  - Increment: units 9 rolls to 0 and carries into tens.
  - Saturates at 99: an increment at 99 is a no-op.
  - o_Score = tens*10 + units, registered.
- High score is a BCD pair, compared as (tens, units) lexicographically.
- States: RUN, FLASH, SHOW_HIGH. Reset state is RUN.
- RUN:
  - Display the live score, or the high score while i_Show_High = 1.
  - o_Blank = 0 and o_Busy = 0.
  - On i_Game_Over:
    - Latch the post-increment live score into the frozen register F.
    - If F > high, set high := F and set the record flag R.
    - Clear the live score to 0.
    - Clear the timer and blink counter, then go to FLASH.
- FLASH:
  - Display F and ignore i_Show_High.
  - o_Blank starts at 1 and toggles every CLKS_PER_BLINK clocks, for 2*BLINK_COUNT half-periods in total.
  - After the last half-period expires, o_Blank = 0. Then go to SHOW_HIGH if R = 1, otherwise go to RUN.
- SHOW_HIGH:
  - Display the high score with o_Blank = 0 for HIGH_SHOW_CLKS clocks.
  - Clear R, then go to RUN.
- i_Score_Inc is honoured in every state. It updates the live score (the next game) without disturbing the frozen display.
- i_Game_Over in FLASH or SHOW_HIGH is ignored.
- i_Score_Inc and i_Game_Over in the same RUN cycle: apply the increment first, then latch. Example: live 41 gives F = 42 and live = 0. Any increment in the cycle of the game-over transition is discarded.
- Equal score (F == high) is not a record; R stays 0.
- Timer width is $clog2 of max(CLKS_PER_BLINK, HIGH_SHOW_CLKS). All arithmetic is unsigned; no value may exceed 99.

## Timing
- Reset (i_Rst_L low, asynchronous):
  - live = 0, high = 0, F = 0, R = 0, state RUN.
  - o_Tens = 0, o_Units = 0, o_Blank = 0, o_Busy = 0, o_Score = 0, o_High_Score = 0.
- Release of reset is synchronous to i_Clk.
- All outputs are registered. An input sampled at edge N is visible on the outputs after edge N+1 (1-cycle latency).
- i_Show_High affects the digits with 1-cycle latency, RUN only.
- Cycle counts are measured from the first output cycle after i_Game_Over:
  - FLASH lasts exactly 2*BLINK_COUNT*CLKS_PER_BLINK cycles.
  - SHOW_HIGH lasts exactly HIGH_SHOW_CLKS cycles.
  - o_Busy = 1 for exactly those cycles.
- Reset asserted mid-FLASH or mid-SHOW_HIGH aborts immediately to RUN with the reset values; the high score is lost.

## Test plan
All scenarios use CLKS_PER_BLINK=4, BLINK_COUNT=2, HIGH_SHOW_CLKS=6.
- **Reset and count:** reset, then 12 i_Score_Inc pulses. Required: o_Tens=1, o_Units=2, o_Score=12, o_Blank=0. After 100 pulses: o_Score=99, with no wrap to 0.
- **First record:** score 7, then i_Game_Over.
  - 16 cycles of FLASH showing 0/7, with o_Blank pattern 1,0,1,0 in 4-cycle runs.
  - Then 6 cycles showing 0/7 with o_Blank=0 (SHOW_HIGH).
  - Then RUN showing 0/0, o_High_Score=7, o_Busy=0 after 22 cycles.
- **No record:** high 7, score 7, then i_Game_Over. Required: FLASH of 16 cycles, then directly RUN; o_High_Score stays 7; no SHOW_HIGH phase.
- **Simultaneous pulses:** score 41, i_Score_Inc and i_Game_Over in the same cycle. Required: FLASH shows 4/2, o_High_Score=42, o_Score=0. Then 3 incs during FLASH: display stays 4/2 and o_Score=3 on return to RUN.
- **Show high:** high 42, live 5, i_Show_High=1 in RUN. Required: digits 4/2 one cycle later, and 0/5 one cycle after release. i_Show_High=1 during FLASH leaves the digits at F.
- **Reset mid-flash:** i_Rst_L low at FLASH cycle 5. Required: all outputs 0 and o_Busy=0 in the same cycle, without waiting for a clock edge.
